// File: rtl/muldiv_pkg.sv
// Shared constants, FSM encoding and funct3 decode for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_REMU   = 3'd7;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic is_div;
    logic rs1_signed;
    logic rs2_signed;
    logic sel_hi;
    logic sel_rem;
  } md_op_t;

  function automatic md_op_t decode_op(input logic [2:0] f3);
    md_op_t op;
    op.is_div     = f3[2];
    op.rs1_signed = (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
                    (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
    op.rs2_signed = (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    op.sel_hi     = (f3 != FUNCT3_MUL) && !f3[2];
    op.sel_rem    = f3[2] && f3[1];
    return op;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage handshake between the pipeline (master) and the multiply/divide unit (slave).
interface ex_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_EX;
  logic                  flush_EX;
  logic [2:0]            funct3_EX;
  logic [DATA_WIDTH-1:0] forward_rs1;
  logic [DATA_WIDTH-1:0] forward_rs2;
  logic                  stall_muldiv_EX;
  logic [DATA_WIDTH-1:0] muldiv_res_EX;
  logic                  muldiv_valid_EX;
  logic                  muldiv_busy;

  modport master (
    output start_EX, flush_EX, funct3_EX, forward_rs1, forward_rs2,
    input  stall_muldiv_EX, muldiv_res_EX, muldiv_valid_EX, muldiv_busy
  );

  modport slave (
    input  start_EX, flush_EX, funct3_EX, forward_rs1, forward_rs2,
    output stall_muldiv_EX, muldiv_res_EX, muldiv_valid_EX, muldiv_busy
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// One combinational iteration: shift-add multiply step or restoring-divide step on {acc, opnd}.
module muldiv_iter_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0] opnd_i,
  input  logic [DATA_WIDTH-1:0] mcand_i,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic [DATA_WIDTH-1:0] opnd_o
);

  logic [DATA_WIDTH:0] sum_s;
  logic [DATA_WIDTH:0] shift_s;
  logic [DATA_WIDTH:0] diff_s;

  // Single step; in divide mode diff_s MSB set means the trial subtraction borrowed
  always_comb begin
    sum_s   = {1'b0, acc_i} + (opnd_i[0] ? {1'b0, mcand_i} : {(DATA_WIDTH+1){1'b0}});
    shift_s = {acc_i, opnd_i[DATA_WIDTH-1]};
    diff_s  = shift_s - {1'b0, mcand_i};
    if (is_div) begin
      if (!diff_s[DATA_WIDTH]) begin
        acc_o  = diff_s[DATA_WIDTH-1:0];
        opnd_o = {opnd_i[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc_o  = shift_s[DATA_WIDTH-1:0];
        opnd_o = {opnd_i[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o  = sum_s[DATA_WIDTH:1];
      opnd_o = {sum_s[0], opnd_i[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M execution unit: 32-cycle shift-add multiply / restoring divide with pipeline stall.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ITER_CNT_WIDTH = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_muldiv_unit_if.slave md
);

  md_state_e                 state_q, state_d;
  logic [ITER_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]     acc_q, acc_d;
  logic [DATA_WIDTH-1:0]     opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0]     mcand_q, mcand_d;
  logic                      is_div_q, is_div_d;
  logic                      sel_hi_q, sel_hi_d;
  logic                      sel_rem_q, sel_rem_d;
  logic                      neg_q, neg_d;
  logic                      rem_neg_q, rem_neg_d;
  logic [DATA_WIDTH-1:0]     res_q, res_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;

  md_op_t                    op_s;
  logic                      rs1_neg_s, rs2_neg_s;
  logic [DATA_WIDTH-1:0]     rs1_mag_s, rs2_mag_s;
  logic                      div_zero_s, div_ovf_s;
  logic [DATA_WIDTH-1:0]     core_acc_s, core_opnd_s;
  logic [2*DATA_WIDTH-1:0]   prod_s, prod_fix_s;
  logic [DATA_WIDTH-1:0]     quo_fix_s, rem_fix_s, final_s;

  assign op_s       = decode_op(md.funct3_EX);
  assign rs1_neg_s  = op_s.rs1_signed & md.forward_rs1[DATA_WIDTH-1];
  assign rs2_neg_s  = op_s.rs2_signed & md.forward_rs2[DATA_WIDTH-1];
  assign rs1_mag_s  = rs1_neg_s ? -md.forward_rs1 : md.forward_rs1;
  assign rs2_mag_s  = rs2_neg_s ? -md.forward_rs2 : md.forward_rs2;
  assign div_zero_s = op_s.is_div & (md.forward_rs2 == {DATA_WIDTH{1'b0}});
  assign div_ovf_s  = op_s.is_div & op_s.rs1_signed &
                      (md.forward_rs1 == INT_MIN) & (md.forward_rs2 == DIV_ZERO_Q);

  muldiv_iter_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .is_div  (is_div_q),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .mcand_i (mcand_q),
    .acc_o   (core_acc_s),
    .opnd_o  (core_opnd_s)
  );

  // Sign fix-up is applied to the last iteration's output so the result lands in DONE already registered
  assign prod_s     = {core_acc_s, core_opnd_s};
  assign prod_fix_s = neg_q ? -prod_s : prod_s;
  assign quo_fix_s  = neg_q ? -core_opnd_s : core_opnd_s;
  assign rem_fix_s  = rem_neg_q ? -core_acc_s : core_acc_s;
  assign final_s    = is_div_q ? (sel_rem_q ? rem_fix_s : quo_fix_s)
                               : (sel_hi_q ? prod_fix_s[2*DATA_WIDTH-1:DATA_WIDTH]
                                           : prod_fix_s[DATA_WIDTH-1:0]);

  // Next-state and datapath update for the IDLE/BUSY/DONE sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    sel_hi_d  = sel_hi_q;
    sel_rem_d = sel_rem_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    res_d     = res_q;
    valid_d   = 1'b0;
    if (md.flush_EX) begin
      state_d = MD_IDLE;
      cnt_d   = {ITER_CNT_WIDTH{1'b0}};
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (md.start_EX) begin
            is_div_d  = op_s.is_div;
            sel_hi_d  = op_s.sel_hi;
            sel_rem_d = op_s.sel_rem;
            neg_d     = rs1_neg_s ^ rs2_neg_s;
            rem_neg_d = rs1_neg_s;
            cnt_d     = {ITER_CNT_WIDTH{1'b0}};
            acc_d     = {DATA_WIDTH{1'b0}};
            opnd_d    = op_s.is_div ? rs1_mag_s : rs2_mag_s;
            mcand_d   = op_s.is_div ? rs2_mag_s : rs1_mag_s;
            if (div_zero_s) begin
              res_d   = op_s.sel_rem ? md.forward_rs1 : DIV_ZERO_Q;
              valid_d = 1'b1;
              state_d = MD_DONE;
            end else if (div_ovf_s) begin
              res_d   = op_s.sel_rem ? {DATA_WIDTH{1'b0}} : INT_MIN;
              valid_d = 1'b1;
              state_d = MD_DONE;
            end else begin
              state_d = MD_BUSY;
            end
          end else begin
            state_d = MD_IDLE;
          end
        end
        MD_BUSY: begin
          acc_d  = core_acc_s;
          opnd_d = core_opnd_s;
          if (cnt_q == ITER_CNT_WIDTH'(DATA_WIDTH - 1)) begin
            cnt_d   = {ITER_CNT_WIDTH{1'b0}};
            res_d   = final_s;
            valid_d = 1'b1;
            state_d = MD_DONE;
          end else begin
            cnt_d   = cnt_q + ITER_CNT_WIDTH'(1);
            state_d = MD_BUSY;
          end
        end
        MD_DONE: begin
          state_d = MD_IDLE;
        end
        default: begin
          state_d = MD_IDLE;
        end
      endcase
    end
    busy_d = (state_d == MD_BUSY);
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= {ITER_CNT_WIDTH{1'b0}};
      acc_q     <= {DATA_WIDTH{1'b0}};
      opnd_q    <= {DATA_WIDTH{1'b0}};
      mcand_q   <= {DATA_WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      sel_hi_q  <= 1'b0;
      sel_rem_q <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      res_q     <= {DATA_WIDTH{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      sel_hi_q  <= sel_hi_d;
      sel_rem_q <= sel_rem_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      res_q     <= res_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // Stall must hit the same cycle the instruction enters EX, so it stays combinational
  assign md.stall_muldiv_EX = md.start_EX & ~md.flush_EX & (state_q != MD_DONE);
  assign md.muldiv_res_EX   = res_q;
  assign md.muldiv_valid_EX = valid_q;
  assign md.muldiv_busy     = busy_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Table-driven scoreboard bench for ex_muldiv_unit plus flush, reset and back-to-back sequences.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.DATA_WIDTH(32)) md_if ();

  ex_muldiv_unit #(.DATA_WIDTH(32), .ITER_CNT_WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_if)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_seen = 0;
  logic [31:0] sb_q [$];
  logic [31:0] mon_exp;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && md_if.muldiv_valid_EX === 1'b1) begin
      valid_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got res %h exp no result", md_if.muldiv_res_EX);
      end else begin
        mon_exp = sb_q.pop_front();
        check_val("result", md_if.muldiv_res_EX, mon_exp);
      end
    end
  end

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int stalls = 0;
    int seen = -1;
    @(posedge clk); #1;
    md_if.start_EX    = 1'b1;
    md_if.funct3_EX   = f3;
    md_if.forward_rs1 = a;
    md_if.forward_rs2 = b;
    sb_q.push_back(exp);
    for (int c = 0; c < 40 && seen < 0; c++) begin
      @(negedge clk);
      if (md_if.muldiv_valid_EX === 1'b1) seen = c;
      else if (md_if.stall_muldiv_EX === 1'b1) stalls++;
    end
    check_int("latency", seen, lat);
    check_int("stall_cycles", stalls, lat);
    if (seen < 0 && sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
    @(posedge clk); #1;
    md_if.start_EX = 1'b0;
  endtask

  task automatic wait_valid(output int at_cyc);
    at_cyc = -1;
    for (int c = 0; c < 40 && at_cyc < 0; c++) begin
      @(negedge clk);
      if (md_if.muldiv_valid_EX === 1'b1) at_cyc = cyc;
    end
  endtask

  initial begin
    int v1, v2, vbase;

    vecs[0]  = '{FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{FUNCT3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{FUNCT3_MUL,    32'h1234_5678,  32'h0000_0010, 32'h2345_6780, 33};
    vecs[3]  = '{FUNCT3_MULHU,  32'h1234_5678,  32'h0000_0010, 32'h0000_0001, 33};
    vecs[4]  = '{FUNCT3_MULH,   32'h8000_0000,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[5]  = '{FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{FUNCT3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[7]  = '{FUNCT3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[8]  = '{FUNCT3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[9]  = '{FUNCT3_DIVU,   32'h8000_0000,  32'd2,         32'h4000_0000, 33};
    vecs[10] = '{FUNCT3_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[11] = '{FUNCT3_REM,    32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[12] = '{FUNCT3_REMU,   32'd100,        32'd7,         32'h0000_0002, 33};
    vecs[13] = '{FUNCT3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[14] = '{FUNCT3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[15] = '{FUNCT3_REM,    32'd5,          32'd0,         32'h0000_0005, 1};
    vecs[16] = '{FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[17] = '{FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[18] = '{FUNCT3_REMU,   32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 1};
    vecs[19] = '{FUNCT3_DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1};

    rst_n             = 1'b0;
    md_if.start_EX    = 1'b0;
    md_if.flush_EX    = 1'b0;
    md_if.funct3_EX   = 3'd0;
    md_if.forward_rs1 = 32'd0;
    md_if.forward_rs2 = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_res", md_if.muldiv_res_EX, 32'd0);
    check_val("reset_valid", {31'd0, md_if.muldiv_valid_EX}, 32'd0);
    check_val("reset_busy", {31'd0, md_if.muldiv_busy}, 32'd0);
    check_val("reset_stall", {31'd0, md_if.stall_muldiv_EX}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++)
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Back-to-back: start held across the DONE edge, next op swapped in right after it
    @(posedge clk); #1;
    md_if.start_EX = 1'b1; md_if.funct3_EX = FUNCT3_MULH;
    md_if.forward_rs1 = 32'h8000_0000; md_if.forward_rs2 = 32'd2;
    sb_q.push_back(32'hFFFF_FFFF);
    wait_valid(v1);
    @(posedge clk); #1;
    md_if.funct3_EX = FUNCT3_DIV;
    md_if.forward_rs1 = 32'd100; md_if.forward_rs2 = 32'hFFFF_FFF9;
    sb_q.push_back(32'hFFFF_FFF2);
    wait_valid(v2);
    check_int("b2b_first_seen", (v1 >= 0) ? 1 : 0, 1);
    check_int("b2b_gap", v2 - v1, 34);
    @(posedge clk); #1;
    md_if.start_EX = 1'b0;

    // Flush in BUSY at cycle 10
    @(posedge clk); #1;
    md_if.start_EX = 1'b1; md_if.funct3_EX = FUNCT3_MUL;
    md_if.forward_rs1 = 32'd3; md_if.forward_rs2 = 32'd5;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_val("flush_pre_stall", {31'd0, md_if.stall_muldiv_EX}, 32'd1);
    @(posedge clk); #1;
    md_if.flush_EX = 1'b1;
    @(negedge clk);
    check_val("flush_stall_drop", {31'd0, md_if.stall_muldiv_EX}, 32'd0);
    check_val("flush_busy_c10", {31'd0, md_if.muldiv_busy}, 32'd1);
    @(posedge clk); #1;
    md_if.flush_EX = 1'b0; md_if.start_EX = 1'b0;
    @(negedge clk);
    check_val("flush_idle_c11", {31'd0, md_if.muldiv_busy}, 32'd0);
    vbase = valid_seen;
    repeat (40) @(negedge clk);
    check_int("flush_no_valid", valid_seen - vbase, 0);
    run_op(FUNCT3_MUL, 32'd3, 32'd5, 32'd15, 33);

    // Synchronous reset in BUSY at cycle 15
    @(posedge clk); #1;
    md_if.start_EX = 1'b1; md_if.funct3_EX = FUNCT3_DIVU;
    md_if.forward_rs1 = 32'd1000; md_if.forward_rs2 = 32'd3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy_c5", {31'd0, md_if.muldiv_busy}, 32'd1);
    repeat (10) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; md_if.start_EX = 1'b0;
    @(negedge clk);
    check_val("midrst_res", md_if.muldiv_res_EX, 32'd0);
    check_val("midrst_valid", {31'd0, md_if.muldiv_valid_EX}, 32'd0);
    check_val("midrst_busy", {31'd0, md_if.muldiv_busy}, 32'd0);
    check_val("midrst_stall", {31'd0, md_if.stall_muldiv_EX}, 32'd0);
    run_op(FUNCT3_DIVU, 32'd1000, 32'd3, 32'd333, 33);

    repeat (3) @(posedge clk);
    check_int("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV32M execution unit in the EX stage, operating alongside the single-cycle ALU.
- Takes forwarded rs1/rs2 operands and funct3, then runs an iterative 32-step shift-add multiply or restoring divide.
- Stalls the front of the pipeline (IF/ID/ID_EX hold) until the result is ready, then presents a one-cycle-valid result for the EX/MEM register.
- The top level muxes muldiv_res_EX over alu_res_EX when muldiv_valid_EX is high.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- ITER_CNT_WIDTH, 6, width of the iteration counter; must hold DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start_EX  input  1  EX holds an M-extension instruction (opcode OP, funct7=0000001); level, held high while stalled.
- flush_EX  input  1  kill the instruction in EX; aborts any operation.
- funct3_EX  input  3  M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- forward_rs1  input  DATA_WIDTH  forwarded rs1 value (multiplicand/dividend).
- forward_rs2  input  DATA_WIDTH  forwarded rs2 value (multiplier/divisor).
- stall_muldiv_EX  output  1  hold the PC, IF_ID and ID_EX registers; bubble EX_MEM.
- muldiv_res_EX  output  DATA_WIDTH  result; valid only while muldiv_valid_EX=1.
- muldiv_valid_EX  output  1  result valid this cycle; the pipeline advances at this edge.
- muldiv_busy  output  1  state is BUSY (debug/perf counter).

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, counter=0, accumulators=0, muldiv_res_EX=0, muldiv_valid_EX=0, muldiv_busy=0.
- stall_muldiv_EX = start_EX & ~flush_EX & (state != DONE). This is combinational because the stall must take effect in the same cycle the instruction enters EX.
- FSM states and transitions:
  - IDLE: if start_EX & ~flush_EX, latch operands and sign flags and go to BUSY (or to DONE on a special case). Otherwise stay in IDLE.
  - BUSY: perform one iteration per cycle and increment the counter. After iteration DATA_WIDTH (counter==DATA_WIDTH-1), go to DONE. start_EX is ignored here.
  - DONE: muldiv_valid_EX=1, stall deasserts, result is driven from registers. Unconditionally go to IDLE next cycle.
- flush_EX=1 in any state forces IDLE at the next edge. valid stays 0 and no result is produced.
- Latency (normal): start seen in cycle 0; BUSY in cycles 1..32; DONE in cycle 33. Stall is high for cycles 0..32 (33 cycles).
- Back-to-back M instructions: the next instruction enters EX at the edge ending DONE. It is seen in IDLE the following cycle, so there is no overlap and no lost start.
- Operand handling:
  - Signedness per funct3: MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 signed and rs2 unsigned; the others are unsigned.
  - Magnitudes are taken at IDLE.
  - Multiply: 64-bit unsigned shift-add. The product is negated if the operand signs differ. MUL returns [31:0]; MULH* return [63:32].
  - Divide: restoring, one quotient bit per cycle. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
- Special cases (IDLE goes directly to DONE; 1-cycle stall, result in cycle 1):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give the dividend.
  - Signed overflow (DIV with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- All outputs except stall_muldiv_EX are registered. muldiv_res_EX holds its last value outside DONE, and consumers must gate it with valid.
- Reset mid-operation (rst_n=0 in BUSY): behaves as a full reset; there is no partial result.

Decomposition:
- muldiv_pkg holds:
  - funct3 constants FUNCT3_MUL..FUNCT3_REMU.
  - FSM encoding MD_IDLE=2'd0, MD_BUSY=2'd1, MD_DONE=2'd2.
  - constants DIV_ZERO_Q (all ones) and INT_MIN (0x80000000).
- Sub-module muldiv_iter_core: a purely combinational single-iteration step (shift-add or subtract-compare) on {acc, operand}, selected by an is_div input. The top level keeps the FSM, counter, sign fix-up and registers.

Test Plan:
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD), start for 34 cycles → stall high for 33 cycles; in cycle 33 valid=1 and res=0xFFFFFFEB (-21). Also check MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.
- DIV/REM signs: DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIVU 0x80000000/2 → 0x40000000.
- Divide by zero and overflow: DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/-1 → 0x80000000. Each has valid in cycle 1 and exactly 1 stall cycle.
- Back-to-back: MULH then DIV with start held across the DONE edge → two valid pulses 34 cycles apart, no missed start, correct results.
- Flush mid-BUSY: assert flush_EX at cycle 10 → stall drops the same cycle; IDLE at cycle 11; valid never asserted; a following MUL completes normally.
- Reset mid-BUSY: rst_n=0 at cycle 15 for one cycle → all outputs 0, busy 0, state IDLE; the next start produces the correct result.
